delay_unit: RTL and testbench

- Programmable spike delay element for the temporal (race-logic) datapath.
- A rising edge on `in` is detected and re-emitted on `out` as a fixed-width pulse.
- The pulse is emitted a programmable number of `aclk` cycles later, within one gamma cycle.
- Used between neuron/WTA stages to apply per-synapse temporal offsets.

---
 rtl/delay_unit.sv | 115 +++++++++++
 tb/tb_delay_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/delay_unit.sv
// delay_unit: programmable spike delay element for the race-logic datapath.
// A spike edge on `in` is captured together with `delay`. After delay+1
// cycles a PULSE_WIDTH-cycle pulse is emitted on `out`. Only one spike is
// accepted per operation; edges that arrive while counting or pulsing are
// dropped.
// Optional feature macro: DELAY_FALLING_EDGE_EN selects active-low spike
// coding. With it, the idle level of `in` and `out` is 1, a spike is a
// falling edge, and the pulse drives `out` to 0.
module delay_unit #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 4
) (
    input  logic                                 aclk,
    input  logic                                 grst,
    input  logic                                 in,
    input  logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] delay,
    output logic                                 out
);

    localparam int DW  = $clog2(GAMMA_CYCLE_WIDTH);
    // One spare bit on the delay counter, so the largest delay cannot wrap.
    localparam int CW  = DW + 1;
    localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_WIDTH - 1);

`ifdef DELAY_FALLING_EDGE_EN
    // Active-low coding: the line rests high.
    localparam logic IDLE_LVL = 1'b1;
`else
    // Active-high coding: the line rests low.
    localparam logic IDLE_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t         state_q;
    logic           in_prev_q;
    logic           out_q;
    logic [DW-1:0]  dly_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [PCW-1:0] pcnt_q;
    logic [PCW-1:0] pcnt_d;
    logic           edge_s;
    logic           cnt_hit_s;

    // Detect a spike edge and compute the next counter values.
    always_comb begin
        edge_s    = (in != IDLE_LVL) && (in_prev_q == IDLE_LVL);
        cnt_d     = cnt_q + CW'(1);
        pcnt_d    = pcnt_q + PCW'(1);
        cnt_hit_s = (cnt_d == {1'b0, dly_q});
    end

    // Delay FSM with a registered output. The edge register keeps following
    // `in` in every state, so an input held high never re-triggers.
    always_ff @(posedge aclk) begin
        if (!grst) begin
            state_q   <= IDLE;
            in_prev_q <= IDLE_LVL;
            out_q     <= IDLE_LVL;
            dly_q     <= {DW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            pcnt_q    <= {PCW{1'b0}};
        end else begin
            in_prev_q <= in;
            case (state_q)
                IDLE: begin
                    out_q <= IDLE_LVL;
                    if (edge_s) begin
                        dly_q  <= delay;
                        cnt_q  <= {CW{1'b0}};
                        pcnt_q <= {PCW{1'b0}};
                        if (delay == {DW{1'b0}}) begin
                            state_q <= PULSE;
                        end else begin
                            state_q <= COUNT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                COUNT: begin
                    out_q <= IDLE_LVL;
                    cnt_q <= cnt_d;
                    if (cnt_hit_s) begin
                        state_q <= PULSE;
                    end else begin
                        state_q <= COUNT;
                    end
                end
                PULSE: begin
                    out_q <= ~IDLE_LVL;
                    if (pcnt_q == PULSE_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        pcnt_q  <= pcnt_d;
                        state_q <= PULSE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= IDLE_LVL;
                end
            endcase
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_delay_unit.sv
// Self-checking bench for delay_unit: table vectors, hand-written corner
// sequences and a randomized run against a timing-level reference model.
// The polarity follows DELAY_FALLING_EDGE_EN, so all stimulus and
// expectations are written in "active" terms.
module tb_delay_unit;

    localparam int G  = 16;
    localparam int PW = 4;
    localparam int DW = $clog2(G);

`ifdef DELAY_FALLING_EDGE_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          grst = 1'b0;
    logic          in_s = 1'b0;
    logic [DW-1:0] delay_s = '0;
    logic          out_s;

    always #5 aclk = ~aclk;

    delay_unit #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
        .aclk (aclk),
        .grst (grst),
        .in   (in_s),
        .delay(delay_s),
        .out  (out_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: the last accepted spike owns the window
    // [m_start, m_end]. A new spike is accepted only after m_end.
    logic m_prev  = 1'b0;
    int   m_start = -10;
    int   m_end   = -10;

    typedef struct {
        int dly;
        int hold;
        int first;
        int last;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle (active-level input), advance the model, settle
    // 1 time unit after the edge.
    task automatic step(input logic a_in, input int d, input logic rst_n);
        logic [DW-1:0] dv;
        dv = d[DW-1:0];
        @(negedge aclk);
        in_s    = a_in ^ INV;
        delay_s = dv;
        grst    = rst_n;
        @(posedge aclk);
        cyc++;
        if (!rst_n) begin
            m_prev  = 1'b0;
            m_start = -10;
            m_end   = -10;
        end else begin
            if (a_in && !m_prev && (cyc > m_end)) begin
                m_start = cyc + int'(dv) + 1;
                m_end   = cyc + int'(dv) + PW;
            end
            m_prev = a_in;
        end
        #1;
    endtask

    function automatic logic act_out();
        return out_s ^ INV;
    endfunction

    function automatic logic model_out();
        return (cyc >= m_start) && (cyc <= m_end);
    endfunction

    task automatic do_reset();
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("reset_out", act_out(), 1'b0);
    endtask

    // Hand sequence: bit k of the masks drives cycle k (k=0 is spike time t).
    // Delay is d0 before cycle dchg and d1 from it on. Expected active
    // windows are [f1,l1] and [f2,l2] relative to t.
    task automatic run_hand(input string nm, input logic [31:0] in_mask,
                            input logic [31:0] rst_mask, input int d0,
                            input int d1, input int dchg, input int f1,
                            input int l1, input int f2, input int l2,
                            input int nk);
        logic e;
        do_reset();
        step(1'b0, d0, 1'b1);
        step(1'b0, d0, 1'b1);
        for (int k = 0; k < nk; k++) begin
            step(in_mask[k], (k < dchg) ? d0 : d1, ~rst_mask[k]);
            e = ((k >= f1) && (k <= l1)) || ((k >= f2) && (k <= l2));
            check(nm, act_out(), e);
        end
    endtask

    initial begin
        vecs[0] = '{dly: 0,  hold: 4,  first: 1,  last: 4};
        vecs[1] = '{dly: 2,  hold: 4,  first: 3,  last: 6};
        vecs[2] = '{dly: 5,  hold: 4,  first: 6,  last: 9};
        vecs[3] = '{dly: 12, hold: 4,  first: 13, last: 16};
        vecs[4] = '{dly: 15, hold: 4,  first: 16, last: 19};
        vecs[5] = '{dly: 3,  hold: 20, first: 4,  last: 7};

        // Table vectors: reset, then spike at k=0 held for `hold` cycles.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            step(1'b0, vecs[v].dly, 1'b1);
            step(1'b0, vecs[v].dly, 1'b1);
            for (int k = 0; k < 30; k++) begin
                step(k < vecs[v].hold, vecs[v].dly, 1'b1);
                check($sformatf("vec%0d_d%0d", v, vecs[v].dly), act_out(),
                      (k >= vecs[v].first) && (k <= vecs[v].last));
            end
        end

        // Delay changed to 1 while counting does not move the pulse.
        run_hand("dly_change", 32'h0000_000F, 32'h0, 6, 1, 2, 7, 10, -1, -1, 16);
        // Second rise during the pulse produces no extra pulse.
        run_hand("rise_in_pulse", 32'h0000_01E7, 32'h0, 3, 3, 0, 4, 7, -1, -1, 22);
        // Reset mid-COUNT aborts; a later spike with delay 2 is normal.
        run_hand("rst_count", 32'h0000_01C7, 32'h0000_0008, 5, 2, 4, 9, 12, -1, -1, 20);
        // Reset mid-PULSE drops out at once; input still high after the
        // reset counts as a new edge (delay 1).
        run_hand("rst_pulse", 32'h0000_000F, 32'h0000_0004, 0, 1, 3, 1, 1, 5, 8, 14);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, G - 1)),
                 ($urandom_range(0, 99) != 0));
            check("random", act_out(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
